mem_access_ctrl: RTL

- Sequences every load/store issued from the memory-access stage to a variable-latency data memory using a req/ack handshake.
- While an access is outstanding, it stalls the upstream pipeline registers and holds the memory/write-back pipeline register, so the write-back stage sees exactly one result per memory instruction.
- Provides a per-access timeout with a sticky error flag.

---
 rtl/mem_access_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Sequences loads and stores from the memory-access stage to a data memory
// whose latency varies, using a req/ack handshake. While an access is
// outstanding it stalls the pipeline up to and including the memory/write-back
// register, so write-back sees exactly one result per memory instruction.
// Each access has a timeout; a timeout aborts the access, returns zero load
// data and sets a sticky error flag.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   mem_MemRead  memory stage holds a load
//   mem_MemWrite memory stage holds a store
//   mem_addr     effective address from the memory-stage ALU
//   mem_wdata    store data
//   dm_ack       data memory completion (only honoured while dm_req=1)
//   dm_rdata     load data, valid with dm_ack
//   dm_req       registered request to data memory
//   dm_we        1=write, 0=read; valid while dm_req=1
//   dm_addr      latched address
//   dm_wdata     latched store data
//   stall_req    holds the upstream pipeline registers
//   mem_rdata    load result for the memory/write-back register
//   timeout_err  sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_MemRead,
   input  logic              mem_MemWrite,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              stall_req,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Counter value seen on the last permitted REQ cycle.
   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]        r_state;
   logic [7:0]        r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   logic              w_acc;
   logic              w_stall;

   assign w_acc = mem_MemRead | mem_MemWrite;

   // NOTE: every sequential register uses non-blocking assignment so all
   // flops sample their inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_addr  <= mem_addr;
                  r_wdata <= mem_wdata;
                  r_we    <= mem_MemWrite;
                  r_cnt   <= '0;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               r_cnt <= r_cnt + 8'd1;
               // Ack is tested first so an ack on the final cycle wins over
               // the timeout.
               if (dm_ack) begin
                  if (!r_we) begin
                     r_rdata <= dm_rdata;
                  end
                  r_state <= S_DONE;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Mealy in IDLE (a new memory instruction stalls in its first cycle),
   // Moore in REQ; forced low while reset is asserted.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      w_stall = 1'b0;
      if (rst) begin
         case (r_state)
            S_IDLE:  w_stall = w_acc;
            S_REQ:   w_stall = 1'b1;
            default: w_stall = 1'b0;
         endcase
      end
   end

   // dm_req is a straight decode of the state register, so it is glitch-free
   // and drops as soon as the asynchronous reset clears the state.
   assign dm_req      = (r_state == S_REQ);
   assign dm_we       = r_we;
   assign dm_addr     = r_addr;
   assign dm_wdata    = r_wdata;
   assign stall_req   = w_stall;
   assign mem_rdata   = r_rdata;
   assign timeout_err = r_err;

endmodule
